// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcode and FSM state encodings shared by alu_seq and its core.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_NOT  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_EQ   = 4'd7,
        OP_SLTU = 4'd8,
        OP_SLL  = 4'd9,
        OP_SRL  = 4'd10,
        OP_SRA  = 4'd11,
        OP_MUL  = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_core
// Description : Combinational single-cycle ALU datapath (all ops except MUL).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_slt;
    logic             w_sltu;
    logic             w_eq;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} - {1'b0, b};
    assign w_shamt = b[SHW-1:0];
    assign w_slt   = $signed(a) < $signed(b);
    assign w_sltu  = a < b;
    assign w_eq    = a == b;

    // Out-of-range shift amounts (non power-of-two WIDTH) naturally give
    // 0 for logical shifts and all-sign for the arithmetic shift.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        carry    = 1'b0;
        case (op)
            OP_ADD: begin
                result   = w_sum[WIDTH-1:0];
                carry    = w_sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = w_diff[WIDTH-1:0];
                carry    = w_diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_EQ:   result = {{(WIDTH-1){1'b0}}, w_eq};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, w_sltu};
            OP_SLL:  result = a << w_shamt;
            OP_SRL:  result = a >> w_shamt;
            OP_SRA:  result = $unsigned($signed(a) >>> w_shamt);
            default: result = '0;
        endcase
    end

    assign zero = ~|result;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready handshakes and optional
//               iterative shift-add multiply (enabled by ALU_SEQ_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry
);

    state_e           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic             r_carry;

    logic [WIDTH-1:0] w_core_result;
    logic             w_core_zero;
    logic             w_core_overflow;
    logic             w_core_carry;
    logic             w_accept;
    logic             w_is_mul;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign carry     = r_carry;

    alu_seq_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (w_core_result),
        .zero     (w_core_zero),
        .overflow (w_core_overflow),
        .carry    (w_core_carry)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_cnt;

    assign w_is_mul = (op == OP_MUL);

    // One multiplier bit per BUSY cycle; the FSM spends one extra cycle
    // after the last bit to move the accumulator into the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
        end else if (r_state == ST_BUSY && r_cnt != c_CNT_LAST) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_CNT_W'(1);
        end
    end
`else
    assign w_is_mul = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state    <= ST_DONE;
                            r_result   <= w_core_result;
                            r_zero     <= w_core_zero;
                            r_overflow <= w_core_overflow;
                            r_carry    <= w_core_carry;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_BUSY: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state    <= ST_DONE;
                        r_result   <= r_acc[WIDTH-1:0];
                        r_zero     <= ~|r_acc[WIDTH-1:0];
                        r_overflow <= |r_acc[2*WIDTH-1:WIDTH];
                        r_carry    <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=4), either MUL build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int SHM  = (1 << $clog2(W)) - 1;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         carry;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .carry     (carry)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference from the arithmetic definitions: {result, zero, overflow, carry}
    function automatic logic [W+2:0] ref_op(input int ai, input int bi, input int oi);
        int sa, sb, r, o, c, sh;
        logic [W-1:0] rr;
        sa = (ai >= (1 << (W-1))) ? ai - (1 << W) : ai;
        sb = (bi >= (1 << (W-1))) ? bi - (1 << W) : bi;
        sh = bi & SHM;
        r = 0; o = 0; c = 0;
        case (oi)
            0: begin
                r = ai + bi; c = (r > MASK) ? 1 : 0;
                o = (sa + sb > (1 << (W-1)) - 1 || sa + sb < -(1 << (W-1))) ? 1 : 0;
            end
            1: begin
                r = ai - bi; c = (ai < bi) ? 1 : 0;
                o = (sa - sb > (1 << (W-1)) - 1 || sa - sb < -(1 << (W-1))) ? 1 : 0;
            end
            2:  r = ~ai;
            3:  r = ai & bi;
            4:  r = ai | bi;
            5:  r = ai ^ bi;
            6:  r = (sa < sb) ? 1 : 0;
            7:  r = (ai == bi) ? 1 : 0;
            8:  r = (ai < bi) ? 1 : 0;
            9:  r = ai << sh;
            10: r = ai >> sh;
            11: r = sa >>> sh;
            12: if (MUL_ON) begin r = ai * bi; o = (r > MASK) ? 1 : 0; end
            default: r = 0;
        endcase
        r  = r & MASK;
        rr = r[W-1:0];
        return {rr, (r == 0), o[0], c[0]};
    endfunction

    logic [W+2:0] m_out, m_pend;
    bit m_valid, m_idle, m_live, m_started;
    int m_wait;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (rst) begin
            m_valid = 1'b0; m_idle = 1'b1; m_wait = 0; m_out = '0; m_live = 1'b1;
        end else if (m_idle && in_valid) begin
            m_idle = 1'b0; m_live = 1'b0;
            if (op == 4'd12 && MUL_ON) begin
                m_wait = W + 1;
                m_pend = ref_op(int'(a), int'(b), int'(op));
            end else begin
                m_valid = 1'b1;
                m_out = ref_op(int'(a), int'(b), int'(op));
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin m_valid = 1'b1; m_out = m_pend; end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0; m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", int'(in_ready), int'(m_idle));
            chk("out_valid", int'(out_valid), int'(m_valid));
            if (m_valid || m_live)
                chk("result/flags", int'({result, zero, overflow, carry}), int'(m_out));
        end
    end

    task automatic run_op(input string nm, input int ai, input int bi, input int oi,
                          input int lat, input int er, input int ez, input int eo,
                          input int ec, input int hold);
        int n;
        @(negedge clk);
        a = W'(ai); b = W'(bi); op = 4'(oi); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, lat);
        chk({nm, " result"}, int'(result), er);
        chk({nm, " zero"}, int'(zero), ez);
        chk({nm, " overflow"}, int'(overflow), eo);
        chk({nm, " carry"}, int'(carry), ec);
        for (int i = 0; i < hold; i++) begin
            a = 4'h1; b = 4'h1; op = 4'd0; in_valid = 1'b1;
            @(negedge clk);
            chk({nm, " held result"}, int'(result), er);
            chk({nm, " held in_ready"}, int'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " in_ready after consume"}, int'(in_ready), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);

        run_op("add 7+1",  7,   1,   OP_ADD,  1, 'h8, 0, 1, 0, 0);
        run_op("add F+1",  'hF, 1,   OP_ADD,  1, 'h0, 1, 0, 1, 0);
        run_op("sub 3-5",  3,   5,   OP_SUB,  1, 'hE, 0, 0, 1, 0);
        run_op("sub 8-1",  8,   1,   OP_SUB,  1, 'h7, 0, 1, 0, 0);
        run_op("slt 8,1",  8,   1,   OP_SLT,  1, 'h1, 0, 0, 0, 0);
        run_op("sltu 8,1", 8,   1,   OP_SLTU, 1, 'h0, 1, 0, 0, 0);
        run_op("sra 8,2",  8,   2,   OP_SRA,  1, 'hE, 0, 0, 0, 0);
        run_op("not 3",    3,   0,   OP_NOT,  1, 'hC, 0, 0, 0, 0);
        run_op("and C,A",  'hC, 'hA, OP_AND,  1, 'h8, 0, 0, 0, 0);
        run_op("or C,3",   'hC, 3,   OP_OR,   1, 'hF, 0, 0, 0, 0);
        run_op("xor A,F",  'hA, 'hF, OP_XOR,  1, 'h5, 0, 0, 0, 0);
        run_op("eq 5,5",   5,   5,   OP_EQ,   1, 'h1, 0, 0, 0, 0);
        run_op("sll 3,2",  3,   2,   OP_SLL,  1, 'hC, 0, 0, 0, 0);
        run_op("srl 8,3",  8,   3,   OP_SRL,  1, 'h1, 0, 0, 0, 0);
        run_op("mul 5*3",  5,   3,   OP_MUL,  MUL_ON ? 5 : 1, MUL_ON ? 'hF : 0,
               MUL_ON ? 0 : 1, 0, 0, 0);
        run_op("mul 5*4",  5,   4,   OP_MUL,  MUL_ON ? 5 : 1, MUL_ON ? 'h4 : 0,
               MUL_ON ? 0 : 1, MUL_ON ? 1 : 0, 0, 0);
        run_op("rsvd 13",  5,   3,   13,      1, 'h0, 1, 0, 0, 0);
        run_op("backpressure add 2+3", 2, 3, OP_ADD, 1, 'h5, 0, 0, 0, 3);

        // Reset two cycles into a multiply
        @(negedge clk);
        a = 4'h5; b = 4'h3; op = 4'd12; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midmul reset out_valid", int'(out_valid), 0);
        chk("midmul reset in_ready", int'(in_ready), 1);
        chk("midmul reset outputs", int'({result, zero, overflow, carry}), 0);
        run_op("add 1+1 after reset", 1, 1, OP_ADD, 1, 'h2, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Operand width is WIDTH; the opcode is widened to 4 bits.
- Adds shifts, unsigned compare and an iterative shift-add multiply.
- Operands enter and results leave through valid/ready handshakes, so the block can sit between the nvboard switch/button front end and LED/segment display logic, or inside a small datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0] (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  operation select
- out_valid  out  1  result registers hold a result not yet consumed
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB); high-half-nonzero (MUL)
- carry  out  1  carry-out (ADD); borrow (SUB)

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 NOT a, 3 AND, 4 OR, 5 XOR.
  - 6 SLT signed → 1/0; 7 EQ → 1/0; 8 SLTU unsigned → 1/0.
  - 9 SLL a by b[SHW-1:0]; 10 SRL; 11 SRA.
  - 12 MUL, unsigned, low WIDTH bits.
  - 13–15 reserved: result 0, all flags 0 except zero=1.
- ADD: {carry,result} = {0,a}+{0,b}; overflow = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
- SUB: {carry,result} = {0,a}-{0,b}, so carry=1 iff a<b unsigned; overflow = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
- zero = ~|result for every op. For ops other than ADD/SUB/MUL, overflow=carry=0.
- Shift amounts ≥ WIDTH cannot occur for power-of-two WIDTH. For other WIDTH values, SLL/SRL give 0 and SRA gives all-sign.
- FSM has three states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE). Accept = in_valid && in_ready; a, b and op are captured on accept.
  - IDLE→DONE on accept of a single-cycle op. The result is registered, so out_valid is high the cycle after accept (latency 1).
  - IDLE→BUSY on accept of MUL. One multiplier bit is processed per cycle for WIDTH cycles, then the FSM goes to DONE. out_valid rises WIDTH+1 cycles after accept.
  - DONE: out_valid=1. result and flags are held stable while out_ready=0. On out_valid && out_ready → IDLE.
  - Peak throughput is one op per 2 cycles. There is no same-cycle re-accept in DONE.
- MUL:
  - Internal 2*WIDTH-bit accumulator.
  - result = acc[WIDTH-1:0]; overflow = |acc[2W-1:W]; carry = 0.
- in_valid with in_ready=0 is ignored; the producer must hold it.
- Reset (any state, including mid-MUL):
  - state=IDLE; out_valid=0; result=0; zero=0; overflow=0; carry=0; accumulator cleared.
  - in_ready=1 the cycle after reset deasserts.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: op 12 behaves as described above (BUSY state, shift-add datapath).
- Undefined:
  - BUSY state and accumulator are not built.
  - op 12 is treated as reserved: single-cycle, result 0, zero=1, other flags 0.

Decomposition:
- Package alu_seq_pkg holds:
  - the 4-bit opcode enum (OP_ADD…OP_MUL);
  - the state enum (ST_IDLE, ST_BUSY, ST_DONE);
  - OP_W=4.
- The combinational single-cycle datapath is the one natural sub-module: alu_seq_core (a, b, op → result, zero, overflow, carry), so the old 4-bit ALU test vectors can be reused.
- The FSM and multiplier stay in alu_seq.

Test Plan (WIDTH=4):
- ADD a=7,b=1 → out_valid next cycle; result=8, overflow=1, carry=0, zero=0. ADD a=F,b=1 → result=0, zero=1, carry=1.
- SUB a=3,b=5 → result=E, carry=1, overflow=0. SLT a=8,b=1 → 1; SLTU a=8,b=1 → 0; SRA a=8,b=2 → E.
- MUL a=5,b=3 → out_valid exactly 5 cycles after accept; result=F, overflow=0. MUL a=5,b=4 → result=4, overflow=1. in_ready=0 throughout BUSY.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → result/flags stable, in_ready=0, new in_valid ignored. out_ready=1 → IDLE next cycle.
- Reset pulse 2 cycles into MUL → next cycle out_valid=0, in_ready=1, all outputs 0. A following ADD 1+1 → 2.
- Build without ALU_SEQ_MUL_EN: op 12 with a=5,b=3 → latency 1, result=0, zero=1.
